ct_lsu_snoop_ctcq_sched: RTL
============================

// Module: ct_lsu_snoop_ctcq_sched
// PURPOSE
//  Scheduler/controller for the snoop CTC queue (CTCQ) entry array in the LSU snoop path.
//  - Allocates entries for incoming CTC (TLBI/ICI) transactions and steers each 2nd transaction to its owner entry.
//  - Issues one invalidation at a time, in order, to the ICache/TLB invalidation unit and routes its completion back.
//  - Returns bus responses in order and pulses per-entry inv_en to retire entries.
// PARAMETERS
//  ENTRY_NUM  4  number of CTCQ entries (power of 2, >=2)
//  PTR_W      2  log2(ENTRY_NUM)
// PORTS
//  lsu_snoop_clk          in   1          clock
//  lsu_snoop_rst          in   1          synchronous reset, active-high
//  snp_ctc_req_vld        in   1          incoming CTC transaction valid
//  snp_ctc_req_need_2nd   in   1          1st transaction announces a following 2nd transaction
//  snp_ctc_req_rdy        out  1          scheduler accepts transaction
//  ctcq_create_en_x       out  ENTRY_NUM  one-hot create strobe to entries
//  ctcq_vld_x             in   ENTRY_NUM  per-entry valid
//  ctcq_pe_req_x          in   ENTRY_NUM  per-entry ready-to-issue request
//  ctcq_cmplt_x           in   ENTRY_NUM  per-entry has-pending-completion
//  ctcq_2_cmplt_x         in   ENTRY_NUM  per-entry two completions pending
//  sched_inv_req_vld      out  1          invalidation request to ICache/TLB unit
//  sched_inv_req_sel      out  ENTRY_NUM  one-hot entry being issued (mux select)
//  inv_req_rdy            in   1          ICache/TLB unit accepts request
//  ica_tlb_inv_cmplt      in   1          invalidation done (single-cycle pulse)
//  ica_tlb_ctcq_inv_cmplt_x out ENTRY_NUM one-hot completion to in-flight entry
//  ctc_resp_vld           out  1          bus completion response valid
//  ctc_resp_id            out  PTR_W      entry index of response
//  ctc_resp_rdy           in   1          bus accepts response
//  ctcq_inv_en_x          out  ENTRY_NUM  one-hot retire strobe (= response handshake)
//  sched_perf_issue_cnt   out  16         issued invalidations (optional feature)
//  sched_perf_full_cnt    out  16         cycles req_vld stalled by full queue (optional feature)
// BEHAVIOUR
//  - Reset (sync, active-high): all pointers point to entry 0; pend_2nd=0; FSM=IDLE.
//    Every output resets to 0, except snp_ctc_req_rdy, which follows ctcq_vld_x combinationally.
//    Entries must be reset in the same cycle.
//  - Allocation:
//    - rdy = pend_2nd ? 1 : !ctcq_vld_x[alloc_ptr].
//    - Accept when vld&&rdy; create_en_x = onehot(pend_2nd ? pend_ptr : alloc_ptr), same cycle.
//    - 1st accept: alloc_ptr++ (wraps ENTRY_NUM-1->0). If need_2nd, set pend_2nd=1 and pend_ptr=old alloc_ptr.
//    - 2nd accept: clear pend_2nd. alloc_ptr is unchanged.
//    - Full means all entries vld and !pend_2nd, giving rdy=0.
//  - Issue FSM, single outstanding:
//    - IDLE: if ctcq_pe_req_x[iss_ptr], go to REQ.
//    - REQ: sched_inv_req_vld=1, sel=onehot(iss_ptr); vld/sel held stable until inv_req_rdy; on rdy go to WAIT.
//    - WAIT: on ica_tlb_inv_cmplt, drive ica_tlb_ctcq_inv_cmplt_x=onehot(iss_ptr) in the same cycle, iss_ptr++, go to IDLE.
//    - Issue-to-next-issue minimum: 1 cycle IDLE + 1 cycle REQ.
//    - A completion pulse outside WAIT is ignored and does not change state.
//  - Response:
//    - ctc_resp_vld = ctcq_cmplt_x[rsp_ptr]; ctc_resp_id = rsp_ptr.
//    - Handshake (vld&&rdy): ctcq_inv_en_x = onehot(rsp_ptr) in the same cycle.
//    - rsp_ptr++ only if !ctcq_2_cmplt_x[rsp_ptr]; 2-trans entries therefore get 2 responses.
//    - When resp_rdy=0, vld/id are held.
//  - Simultaneous events:
//    - Create, completion and retire on different entries in one cycle are all legal and independent.
//    - A create into the entry retiring that cycle is impossible by construction (rdy uses current vld).
//  - Ordering: iss_ptr and rsp_ptr trail alloc_ptr. Entries retire strictly in allocation order.
// CONFIGURATION
//  Macro CT_LSU_CTCQ_SCHED_PERF_EN.
//  - Defined:
//    - sched_perf_issue_cnt += 1 on each REQ handshake.
//    - sched_perf_full_cnt += 1 each cycle with req_vld && !rdy.
//    - Both counters saturate at 16'hFFFF and clear on reset.
//  - Undefined: no counter flops; both outputs tied to 0.
// TESTING
//  - Reset mid-WAIT on entry 2: after reset, iss/rsp/alloc ptr=0, req_vld=0, resp_vld=0, and the next create goes to entry 0.
//  - Single TLBI_ALL (need_2nd=0):
//    - create_en_x=4'b0001.
//    - pe_req -> req_vld with sel=0001; rdy=1.
//    - cmplt pulse -> ica_tlb_ctcq_inv_cmplt_x=0001.
//    - resp handshake -> inv_en_x=0001 exactly once.
//  - ICI_VA two-part: 1st (need_2nd=1) then 2nd both create into entry 0.
//    - alloc_ptr=1 after the 1st create.
//    - Two responses, id=0 each, with two inv_en_x=0001 pulses; rsp_ptr advances only after the second.
//  - Fill 4 entries with inv_req_rdy=0: 5th req sees rdy=0.
//    - With the macro defined, perf_full_cnt counts the stall cycles.
//    - After entry 0 retires, the 5th request goes to entry 0 (wrap).
//  - Backpressure: ctc_resp_rdy=0 for 3 cycles.
//    - resp_vld/id are held and inv_en_x=0 throughout.
//    - In the same window, the entry-1 issue still proceeds and completes.
//  - Spurious ica_tlb_inv_cmplt in IDLE: no ica_tlb_ctcq_inv_cmplt_x pulse and iss_ptr unchanged.

Source files
------------

// File: rtl/ct_lsu_snoop_ctcq_sched_if.sv
// Snoop CTCQ scheduler bundle: transaction intake, per-entry status, invalidation
// issue/completion and bus response channels. The scheduler uses the slave modport.
interface ct_lsu_snoop_ctcq_sched_if #(
  parameter int ENTRY_NUM = 4,
  parameter int PTR_W     = 2
);
  logic                 snp_ctc_req_vld;
  logic                 snp_ctc_req_need_2nd;
  logic                 snp_ctc_req_rdy;
  logic [ENTRY_NUM-1:0] ctcq_create_en_x;
  logic [ENTRY_NUM-1:0] ctcq_vld_x;
  logic [ENTRY_NUM-1:0] ctcq_pe_req_x;
  logic [ENTRY_NUM-1:0] ctcq_cmplt_x;
  logic [ENTRY_NUM-1:0] ctcq_2_cmplt_x;
  logic                 sched_inv_req_vld;
  logic [ENTRY_NUM-1:0] sched_inv_req_sel;
  logic                 inv_req_rdy;
  logic                 ica_tlb_inv_cmplt;
  logic [ENTRY_NUM-1:0] ica_tlb_ctcq_inv_cmplt_x;
  logic                 ctc_resp_vld;
  logic [PTR_W-1:0]     ctc_resp_id;
  logic                 ctc_resp_rdy;
  logic [ENTRY_NUM-1:0] ctcq_inv_en_x;
  logic [15:0]          sched_perf_issue_cnt;
  logic [15:0]          sched_perf_full_cnt;

  modport slave (
    input  snp_ctc_req_vld, snp_ctc_req_need_2nd,
    input  ctcq_vld_x, ctcq_pe_req_x, ctcq_cmplt_x, ctcq_2_cmplt_x,
    input  inv_req_rdy, ica_tlb_inv_cmplt, ctc_resp_rdy,
    output snp_ctc_req_rdy, ctcq_create_en_x,
    output sched_inv_req_vld, sched_inv_req_sel, ica_tlb_ctcq_inv_cmplt_x,
    output ctc_resp_vld, ctc_resp_id, ctcq_inv_en_x,
    output sched_perf_issue_cnt, sched_perf_full_cnt
  );

  modport master (
    output snp_ctc_req_vld, snp_ctc_req_need_2nd,
    output ctcq_vld_x, ctcq_pe_req_x, ctcq_cmplt_x, ctcq_2_cmplt_x,
    output inv_req_rdy, ica_tlb_inv_cmplt, ctc_resp_rdy,
    input  snp_ctc_req_rdy, ctcq_create_en_x,
    input  sched_inv_req_vld, sched_inv_req_sel, ica_tlb_ctcq_inv_cmplt_x,
    input  ctc_resp_vld, ctc_resp_id, ctcq_inv_en_x,
    input  sched_perf_issue_cnt, sched_perf_full_cnt
  );
endinterface

// File: rtl/ct_lsu_snoop_ctcq_sched.sv
// Snoop CTCQ scheduler: in-order allocation, single-outstanding invalidation issue and
// in-order response/retire. Perf counters exist only when CT_LSU_CTCQ_SCHED_PERF_EN is defined.
module ct_lsu_snoop_ctcq_sched #(
  parameter int ENTRY_NUM = 4,
  parameter int PTR_W     = 2
) (
  input logic                      lsu_snoop_clk,
  input logic                      lsu_snoop_rst,
  ct_lsu_snoop_ctcq_sched_if.slave sif
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [ENTRY_NUM-1:0] OH_ZERO = {ENTRY_NUM{1'b0}};

  function automatic logic [ENTRY_NUM-1:0] onehot_f(input logic [PTR_W-1:0] idx);
    onehot_f = ENTRY_NUM'(1'b1) << idx;
  endfunction

  logic [PTR_W-1:0] alloc_ptr_r;
  logic [PTR_W-1:0] pend_ptr_r;
  logic             pend_2nd_r;
  logic [PTR_W-1:0] iss_ptr_r;
  logic [PTR_W-1:0] rsp_ptr_r;
  state_e           state_r;
  state_e           state_s;
  logic             req_rdy_s;
  logic             req_acc_s;
  logic             inv_done_s;
  logic             rsp_hs_s;
  logic             rsp_adv_s;

  // Intake ready: a pending 2nd transaction always targets its owner entry.
  always_comb begin
    req_rdy_s = 1'b1;
    if (pend_2nd_r) begin
      req_rdy_s = 1'b1;
    end else begin
      req_rdy_s = !sif.ctcq_vld_x[alloc_ptr_r];
    end
  end

  assign req_acc_s            = sif.snp_ctc_req_vld && req_rdy_s;
  assign sif.snp_ctc_req_rdy  = req_rdy_s;
  assign sif.ctcq_create_en_x = req_acc_s ? onehot_f(pend_2nd_r ? pend_ptr_r : alloc_ptr_r) : OH_ZERO;

  // Allocation pointer and 2nd-transaction tracking.
  always_ff @(posedge lsu_snoop_clk) begin
    if (lsu_snoop_rst) begin
      alloc_ptr_r <= PTR_ZERO;
      pend_ptr_r  <= PTR_ZERO;
      pend_2nd_r  <= 1'b0;
    end else if (req_acc_s) begin
      if (pend_2nd_r) begin
        pend_2nd_r <= 1'b0;
      end else begin
        alloc_ptr_r <= alloc_ptr_r + PTR_ONE;
        if (sif.snp_ctc_req_need_2nd) begin
          pend_2nd_r <= 1'b1;
          pend_ptr_r <= alloc_ptr_r;
        end
      end
    end
  end

  // Issue FSM next state; completions outside WAIT are ignored.
  always_comb begin
    state_s    = state_r;
    inv_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sif.ctcq_pe_req_x[iss_ptr_r]) state_s = ST_REQ;
        else                              state_s = ST_IDLE;
      end
      ST_REQ: begin
        if (sif.inv_req_rdy) state_s = ST_WAIT;
        else                 state_s = ST_REQ;
      end
      ST_WAIT: begin
        if (sif.ica_tlb_inv_cmplt) begin
          state_s    = ST_IDLE;
          inv_done_s = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Issue FSM state and issue pointer.
  always_ff @(posedge lsu_snoop_clk) begin
    if (lsu_snoop_rst) begin
      state_r   <= ST_IDLE;
      iss_ptr_r <= PTR_ZERO;
    end else begin
      state_r <= state_s;
      if (inv_done_s) iss_ptr_r <= iss_ptr_r + PTR_ONE;
    end
  end

  assign sif.sched_inv_req_vld        = (state_r == ST_REQ);
  assign sif.sched_inv_req_sel        = (state_r == ST_REQ) ? onehot_f(iss_ptr_r) : OH_ZERO;
  assign sif.ica_tlb_ctcq_inv_cmplt_x = inv_done_s ? onehot_f(iss_ptr_r) : OH_ZERO;

  // Two-completion entries hold the response pointer for a second handshake.
  assign rsp_hs_s          = sif.ctcq_cmplt_x[rsp_ptr_r] && sif.ctc_resp_rdy;
  assign rsp_adv_s         = rsp_hs_s && !sif.ctcq_2_cmplt_x[rsp_ptr_r];
  assign sif.ctc_resp_vld  = sif.ctcq_cmplt_x[rsp_ptr_r];
  assign sif.ctc_resp_id   = rsp_ptr_r;
  assign sif.ctcq_inv_en_x = rsp_hs_s ? onehot_f(rsp_ptr_r) : OH_ZERO;

  // Response pointer.
  always_ff @(posedge lsu_snoop_clk) begin
    if (lsu_snoop_rst) begin
      rsp_ptr_r <= PTR_ZERO;
    end else if (rsp_adv_s) begin
      rsp_ptr_r <= rsp_ptr_r + PTR_ONE;
    end
  end

`ifdef CT_LSU_CTCQ_SCHED_PERF_EN
  logic [15:0] issue_cnt_r;
  logic [15:0] full_cnt_r;

  // Saturating issue and full-stall counters.
  always_ff @(posedge lsu_snoop_clk) begin
    if (lsu_snoop_rst) begin
      issue_cnt_r <= 16'd0;
      full_cnt_r  <= 16'd0;
    end else begin
      if ((state_r == ST_REQ) && sif.inv_req_rdy && (issue_cnt_r != 16'hFFFF))
        issue_cnt_r <= issue_cnt_r + 16'd1;
      if (sif.snp_ctc_req_vld && !req_rdy_s && (full_cnt_r != 16'hFFFF))
        full_cnt_r <= full_cnt_r + 16'd1;
    end
  end

  assign sif.sched_perf_issue_cnt = issue_cnt_r;
  assign sif.sched_perf_full_cnt  = full_cnt_r;
`else
  assign sif.sched_perf_issue_cnt = 16'd0;
  assign sif.sched_perf_full_cnt  = 16'd0;
`endif
endmodule
